// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: op encodings and FSM states shared by the HI/LO multiply/divide unit
package mips_muldiv_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
endpackage

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: issue/result bundle between the CPU control unit and the HI/LO multiply/divide unit
interface mips_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, src_a, src_b, input busy, done, div_by_zero, hi, lo);
  modport slave (input start, op, src_a, src_b, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mips_muldiv_div_step.sv
// mips_muldiv_div_step: one combinational restoring-division step (shift in a dividend bit, trial subtract)
module mips_muldiv_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic             q_bit
);
  logic [WIDTH:0] t, diff;
  always_comb begin
    t = {rem, dvd_msb};
    diff = t - {1'b0, divisor};
    q_bit = !diff[WIDTH];
    rem_nx = q_bit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  end
endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative HI/LO multiply/divide unit owning HI/LO; MULDIV_FAST_MUL_EN selects a single-cycle multiply
module mips_muldiv #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  mips_muldiv_if.slave bus
);
  import mips_muldiv_pkg::*;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef MULDIV_FAST_MUL_EN
  localparam state_e MUL_NX = S_FIX;
`else
  localparam state_e MUL_NX = S_CALC;
`endif
  state_e state, state_nx;
  logic [WIDTH-1:0] m, hi_q, lo_q, mag_a, mag_b, rem_nx, q_fix, r_fix;
  logic [2*WIDTH-1:0] acc, mul_init, prod_fix;
  logic [WIDTH:0] mul_sum;
  logic [CNT_W-1:0] cnt;
  logic is_div, neg_q, neg_r, dz, done_q, dbz_q;
  logic idle_start, go_mul, go_div, go_mt, sgn, sa, sb, q_bit;
  mips_muldiv_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(acc[2*WIDTH-1:WIDTH]),
    .dvd_msb(acc[WIDTH-1]),
    .divisor(m),
    .rem_nx(rem_nx),
    .q_bit(q_bit)
  );
  always_comb begin
    idle_start = state == S_IDLE && bus.start;
    go_mul = idle_start && (bus.op == MD_MULT || bus.op == MD_MULTU);
    go_div = idle_start && (bus.op == MD_DIV || bus.op == MD_DIVU);
    go_mt = idle_start && (bus.op == MD_MTHI || bus.op == MD_MTLO);
    sgn = bus.op == MD_MULT || bus.op == MD_DIV;
    sa = sgn && bus.src_a[WIDTH-1];
    sb = sgn && bus.src_b[WIDTH-1];
    mag_a = sa ? -bus.src_a : bus.src_a;
    mag_b = sb ? -bus.src_b : bus.src_b;
`ifdef MULDIV_FAST_MUL_EN
    mul_init = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
    mul_init = {{WIDTH{1'b0}}, mag_b};
`endif
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    prod_fix = neg_q ? -acc : acc;
    q_fix = dz ? '1 : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    state_nx = go_div ? S_CALC :
               go_mul ? MUL_NX :
               (state == S_CALC && cnt == CNT_W'(1)) ? S_FIX :
               state == S_FIX ? S_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (go_mul || go_div) begin
      m <= go_div ? mag_b : mag_a;
      acc <= go_div ? {{WIDTH{1'b0}}, mag_a} : mul_init;
      cnt <= CNT_W'(WIDTH);
      is_div <= go_div;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      dz <= bus.src_b == '0;
    end else if (state == S_CALC) begin
      cnt <= cnt - CNT_W'(1);
      acc <= is_div ? {rem_nx, acc[WIDTH-2:0], q_bit} : {mul_sum, acc[WIDTH-1:1]};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      done_q <= state == S_FIX || go_mt;
      if (go_mt && bus.op == MD_MTHI) hi_q <= bus.src_a;
      if (go_mt && bus.op == MD_MTLO) lo_q <= bus.src_a;
      if (go_div) dbz_q <= 1'b0;
      if (state == S_FIX && is_div) begin
        hi_q <= r_fix;
        lo_q <= q_fix;
        dbz_q <= dz;
      end else if (state == S_FIX) begin
        {hi_q, lo_q} <= prod_fix;
      end
    end
  end
  assign bus.busy = state != S_IDLE;
  assign bus.done = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: random and directed checks of mips_muldiv against a latency/arithmetic reference model
module tb_mips_muldiv;
  import mips_muldiv_pkg::*;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic armed = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi, m_lo;
  logic m_dbz, m_done, p_div, p_dz;
  logic [2*W-1:0] p_res;
  int m_cnt;
  int n, hold;
  mips_muldiv_if #(.WIDTH(W)) bus();
  mips_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {hi,lo} from plain 64-bit arithmetic; SV division truncates toward zero
  function automatic logic [2*W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [2*W-1:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    if ((op == MD_DIV || op == MD_DIVU) && b == '0) return {a, {W{1'b1}}};
    if (op == MD_MULT) return sa * sb;
    if (op == MD_MULTU) return ua * ub;
    if (op == MD_DIV) return {W'(sa % sb), W'(sa / sb)};
    return {W'(ua % ub), W'(ua / ub)};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return W'($urandom_range(0, 40)) - W'(20);
      default: return W'($urandom);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_hi <= '0;
      m_lo <= '0;
      m_dbz <= 1'b0;
      m_done <= 1'b0;
      m_cnt <= 0;
      armed <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          {m_hi, m_lo} <= p_res;
          m_done <= 1'b1;
          if (p_div) m_dbz <= p_dz;
        end
      end else if (bus.start && bus.op <= MD_DIVU) begin
        p_res <= ref_result(bus.op, bus.src_a, bus.src_b);
        p_div <= bus.op[1];
        p_dz <= bus.src_b == '0;
        m_cnt <= bus.op[1] ? DIV_LAT : MUL_LAT;
        if (bus.op[1]) m_dbz <= 1'b0;
      end else if (bus.start && bus.op == MD_MTHI) begin
        m_hi <= bus.src_a;
        m_done <= 1'b1;
      end else if (bus.start && bus.op == MD_MTLO) begin
        m_lo <= bus.src_a;
        m_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", bus.busy, m_cnt != 0);
      chk("done", bus.done, m_done);
      chk("div_by_zero", bus.div_by_zero, m_dbz);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", bus.done, 1);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ehi, input logic [W-1:0] elo);
    issue(op, a, b);
    wait_done();
    chk({name, "_hi"}, bus.hi, ehi);
    chk({name, "_lo"}, bus.lo, elo);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("multu_busy_cycles", n, MUL_LAT);
    chk("multu_done", bus.done, 1);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    run("mult_m7x3", MD_MULT, -32'sd7, 32'sd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("div_m7d2", MD_DIV, -32'sd7, 32'sd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run("divu_zero", MD_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    chk("divu_zero_flag", bus.div_by_zero, 1);
    run("divu_9d4", MD_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);
    chk("divu_9d4_flag", bus.div_by_zero, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = MD_MTHI;
    bus.src_a = 32'h1234;
    @(negedge clk);
    chk("mthi_done", bus.done, 1);
    chk("mthi_busy", bus.busy, 0);
    bus.op = MD_MTLO;
    bus.src_a = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mtlo_done", bus.done, 1);
    chk("mtlo_busy", bus.busy, 0);
    chk("mt_hi", bus.hi, 32'h1234);
    chk("mt_lo", bus.lo, 32'h5678);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = MD_MULTU;
    bus.src_a = 32'd6;
    bus.src_b = 32'd7;
    @(negedge clk);
    chk("held_busy", bus.busy, 1);
    bus.src_a = 32'd9;
    wait_done();
    chk("held_lo", bus.lo, 32'd42);
    chk("held_hi", bus.hi, 32'd0);
    @(negedge clk);
    chk("b2b_busy", bus.busy, 1);
    bus.start = 1'b0;
    wait_done();
    chk("b2b_lo", bus.lo, 32'd63);
    issue(MD_MULTU, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    run("multu_3x5", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
    for (int i = 0; i < 150; i++) begin
      hold = $urandom_range(1, 3);
      @(negedge clk);
      bus.start = 1'b1;
      for (int j = 0; j < hold; j++) begin
        bus.op = 3'($urandom_range(0, 7));
        bus.src_a = pick();
        bus.src_b = pick();
        @(negedge clk);
      end
      bus.start = 1'b0;
      n = 0;
      while (bus.busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("rand_idle_timeout", bus.busy, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
